// File: rtl/sat_accum.sv
// sat_accum: streaming frame accumulator with per-step saturating add.
// Folds len samples (0 = 2^COUNT_W) into one WIDTH-bit frame sum.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   mode[1:0]           00 usat, 01 ssat, 1x wrap (sampled at frame start)
//   len[COUNT_W-1:0]    samples per frame (sampled at frame start)
//   in_valid/in_ready   sample handshake, in_data[WIDTH-1:0]
//   out_valid/out_ready frame-sum handshake, out_data[WIDTH-1:0]
//   out_sat             sticky saturation flag (only with SAT_ACCUM_FLAG_EN)
//
// Optional feature macro: SAT_ACCUM_FLAG_EN
module sat_accum #(
  parameter int WIDTH   = 12,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef SAT_ACCUM_FLAG_EN
  ,
  output logic               out_sat
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
  localparam logic [WIDTH-1:0] U_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;

  logic [WIDTH:0]     sum_w;
  logic               ovf;
  logic [WIDTH-1:0]   add_res;

  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = acc_q;

  // Signed overflow: like-signed operands, result sign flipped.
  assign sum_w = {1'b0, acc_q} + {1'b0, in_data};
  assign ovf   = (acc_q[WIDTH-1] == in_data[WIDTH-1]) &&
                 (sum_w[WIDTH-1] != acc_q[WIDTH-1]);

  always_comb begin
    add_res = sum_w[WIDTH-1:0];
    unique case (1'b1)
      mode_q == 2'b00: begin
        if (sum_w[WIDTH]) add_res = U_MAX;
      end
      mode_q == 2'b01: begin
        if (ovf) add_res = acc_q[WIDTH-1] ? S_MIN : S_MAX;
      end
      default: add_res = sum_w[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d  = in_data;
          mode_d = mode;
          // len==0 wraps to 2^COUNT_W-1 remaining samples
          cnt_d  = len - CNT_ONE;
          state_d = (len == CNT_ONE) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = add_res;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

`ifdef SAT_ACCUM_FLAG_EN
  logic sat_q, sat_d;
  logic start, step, add_sat;

  assign start   = (state_q == S_IDLE) && in_valid;
  assign step    = (state_q == S_ACCUM) && in_valid;
  assign add_sat = ((mode_q == 2'b00) && sum_w[WIDTH]) ||
                   ((mode_q == 2'b01) && ovf);

  always_comb begin
    sat_d = sat_q;
    if (start)     sat_d = 1'b0;
    else if (step) sat_d = sat_q | add_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end

  assign out_sat = sat_q;
`endif

endmodule

// File: doc/sat_accum.md
Name: sat_accum

Overview:
- Streaming frame accumulator placed directly upstream of the result bus.
- Consumes 12-bit samples over a valid/ready handshake and folds each sample into a running sum using the team's 12-bit adder modes: unsigned saturate, signed saturate, or wrap.
- After `len` samples it presents one 12-bit frame sum on a valid/ready output.
- Sequential core: a 3-state FSM, a sample down-counter and the accumulator register.

Parameters:
- WIDTH, 12, sample and sum width. All saturation constants scale with WIDTH.
- COUNT_W, 8, width of the `len` input and the internal sample counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  00 unsigned saturate, 01 signed saturate, 10/11 wrap. Sampled at frame start.
- len  input  COUNT_W  samples per frame. 0 means 2^COUNT_W. Sampled at frame start.
- in_valid  input  1  sample valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  WIDTH  sample.
- out_valid  output  1  frame sum valid.
- out_ready  input  1  downstream accepts the sum.
- out_data  output  WIDTH  frame sum.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, cnt=0, mode_q=0, out_valid=0, out_data=0, in_ready=1. A partial frame is discarded. Outputs take reset values immediately, not on the next clock edge.
- in_ready = (state != HOLD). out_valid = (state == HOLD). out_data = acc, registered.
- A transfer occurs on a rising edge when valid and ready are both 1.
- IDLE, sample accepted (frame start):
  - acc <= in_data; mode_q <= mode; cnt <= len-1, computed modulo 2^COUNT_W, so len=0 gives 2^COUNT_W-1 remaining.
  - If len==1: go to HOLD. Otherwise go to ACCUM.
- ACCUM, sample accepted:
  - acc <= f(acc, in_data, mode_q); cnt <= cnt-1.
  - If cnt==1 before the decrement: go to HOLD.
- ACCUM with no transfer: hold all state. Bubbles are allowed with no timeout.
- HOLD:
  - Hold out_data stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE, with out_valid=0 the next cycle.
  - No input is accepted in HOLD. There is no output-to-input bypass, so a new frame starts no earlier than the cycle after the handshake.
- Latency: out_valid rises the cycle after the last sample transfer. Throughput is len samples plus at least 1 HOLD cycle per frame.
- Arithmetic, with s = acc + in_data computed at WIDTH+1 bits:
  - Mode 00: if s[WIDTH] is 1, result = all ones (0xFFF). Otherwise result = s[WIDTH-1:0].
  - Mode 01: signed overflow occurs when both operand MSBs are equal and the result MSB differs. On overflow, result = 0x7FF if acc MSB is 0, or 0x800 if acc MSB is 1. Otherwise result = s[WIDTH-1:0].
  - Modes 10/11: result = s[WIDTH-1:0], wrap.
- Saturation is applied at every step, not only at the end. Example, mode 00: 0xFFF, 0x001, then 0xFFE gives 0xFFF after step 2 and 0xFFF after step 3.
- Changes to mode or len mid-frame are ignored until the next frame start.
- in_valid asserted in HOLD is not consumed; the upstream stage must hold its data.

Optional Feature:
- Macro: SAT_ACCUM_FLAG_EN.
- Defined:
  - Adds output `out_sat` (1 bit), valid with out_data. Reset value 0.
  - Cleared at frame start.
  - Set sticky if any addition in the frame saturated: mode 00 carry out, mode 01 signed overflow. Never set in modes 10/11.
  - Held stable in HOLD.
- Undefined: the port does not exist and no flag logic is generated.

Test Plan:
- Unsigned saturation, mode=00, len=3, samples 0x800, 0x700, 0x100 → out_data=0xFFF (0xF00, then 0x1000 saturated); out_sat=1 with flag enabled.
- Signed saturation, two frames:
  - mode=01, len=2, samples 0x7F0, 0x020 → out_data=0x7FF.
  - Next frame mode=01, len=2, samples 0x800, 0xFFF → out_data=0x800.
- Wrap and defaults: mode=10, len=2, samples 0xFFF, 0x002 → out_data=0x001, out_sat=0. Single-sample frame len=1, sample 0x123 → out_valid the next cycle with out_data=0x123.
- Backpressure: len=2, out_ready held 0 for 5 cycles → out_valid=1, out_data constant, in_ready=0, and a held in_valid sample is not consumed; a pulse of out_ready → IDLE, and the held sample starts the next frame.
- len=0: mode=10, 256 samples of 0x001 with random in_valid gaps → out_valid only after the 256th transfer, out_data=0x100.
- Reset mid-frame: len=4, mode=10, pull rst_n low after 2 samples → out_valid=0 and in_ready=1 immediately; a following frame of len=2 with 0x010 and 0x020 → out_data=0x030.
